// File: rtl/pc_sequencer.sv
// Program counter and interrupt/exception sequencer for the single-cycle MIPS core.
// Kernel mode is pc[31]; events vector to fixed ROM words and hand back a return address for $26.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        irq,
    input  logic        illegal_op,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        squash,
    output logic        xp_we,
    output logic [31:0] xp_data,
    output logic        int_ack,
    output logic [1:0]  cause
);

    typedef enum logic [1:0] {
        CauseNone = 2'd0,
        CauseIrq  = 2'd1,
        CauseExc  = 2'd2
    } cause_e;

    logic [31:0] pc_q, pc_d;
    logic        irq_pending_q, irq_pending_d;
    logic        irq_prev_q;
    logic [1:0]  cause_q, cause_d;

    logic        kernel;
    logic        irq_edge;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] jr_clean;
    logic [31:0] jr_pc;

    assign kernel    = pc_q[31];
    assign irq_edge  = irq & ~irq_prev_q;
    assign seq_pc    = pc_q + 32'd4;
    assign branch_pc = seq_pc + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_pc   = {pc_q[31:28], jump_target, 2'b00};
    assign jr_clean  = jr_target & 32'hFFFF_FFFC;
    // User code may not set the kernel bit through a register jump.
    assign jr_pc     = kernel ? jr_clean : (jr_clean & 32'h7FFF_FFFF);

    always_comb begin
        pc_d          = seq_pc;
        squash        = 1'b0;
        xp_we         = 1'b0;
        xp_data       = seq_pc;
        int_ack       = 1'b0;
        cause_d       = cause_q;
        irq_pending_d = irq_pending_q | irq_edge;

        if (stall) begin
            pc_d = pc_q;
        end else if (illegal_op && !kernel) begin
            pc_d    = EXC_VEC;
            squash  = 1'b1;
            xp_we   = 1'b1;
            xp_data = seq_pc;
            cause_d = CauseExc;
        end else if (irq_pending_q && !kernel) begin
            // Return to the squashed instruction so it re-executes.
            pc_d          = IRQ_VEC;
            squash        = 1'b1;
            xp_we         = 1'b1;
            xp_data       = pc_q;
            int_ack       = 1'b1;
            cause_d       = CauseIrq;
            irq_pending_d = irq_edge;
        end else begin
            case (pc_src)
                2'd1: pc_d = branch_taken ? branch_pc : seq_pc;
                2'd2: pc_d = jump_pc;
                2'd3: pc_d = jr_pc;
                default: pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            irq_pending_q <= 1'b0;
            irq_prev_q    <= 1'b0;
            cause_q       <= CauseNone;
        end else begin
            pc_q          <= pc_d;
            irq_pending_q <= irq_pending_d;
            irq_prev_q    <= irq;
            cause_q       <= cause_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = seq_pc;
    assign cause    = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of per-cycle vectors with a next-state scoreboard,
// plus a hand-driven asynchronous reset in the middle of a run.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        irq;
    logic        illegal_op;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        squash;
    logic        xp_we;
    logic [31:0] xp_data;
    logic        int_ack;
    logic [1:0]  cause;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .irq          (irq),
        .illegal_op   (illegal_op),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .squash       (squash),
        .xp_we        (xp_we),
        .xp_data      (xp_data),
        .int_ack      (int_ack),
        .cause        (cause)
    );

    typedef struct {
        logic        stall;
        logic        irq;
        logic        ill;
        logic [1:0]  src;
        logic        taken;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] jrt;
        logic [31:0] e_pc;
        logic        e_sq;
        logic        e_we;
        logic [31:0] e_xd;
        logic        e_ack;
        logic [31:0] e_npc;
        logic [1:0]  e_cause;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] npc;
        logic [1:0]  cause;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic st, input logic iq, input logic il, input logic [1:0] src,
                       input logic tk, input logic [15:0] imm, input logic [25:0] jt,
                       input logic [31:0] jrt, input logic [31:0] e_pc, input logic e_sq,
                       input logic e_we, input logic [31:0] e_xd, input logic e_ack,
                       input logic [31:0] e_npc, input logic [1:0] e_cause);
        vec_t v;
        v = '{st, iq, il, src, tk, imm, jt, jrt, e_pc, e_sq, e_we, e_xd, e_ack, e_npc, e_cause};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 0; irq = 0; illegal_op = 0; pc_src = 0; branch_taken = 0;
        branch_imm = 0; jump_target = 0; jr_target = 0;
    endtask

    task automatic step(input int i);
        vec_t v;
        exp_t e;
        v = vecs[i];
        @(negedge clk);
        stall = v.stall; irq = v.irq; illegal_op = v.ill; pc_src = v.src;
        branch_taken = v.taken; branch_imm = v.imm; jump_target = v.jt; jr_target = v.jrt;
        #1;
        chk($sformatf("v%0d pc", i), pc, v.e_pc);
        chk($sformatf("v%0d pc_plus4", i), pc_plus4, v.e_pc + 32'd4);
        chk($sformatf("v%0d squash", i), {31'b0, squash}, {31'b0, v.e_sq});
        chk($sformatf("v%0d xp_we", i), {31'b0, xp_we}, {31'b0, v.e_we});
        chk($sformatf("v%0d int_ack", i), {31'b0, int_ack}, {31'b0, v.e_ack});
        if (v.e_we) chk($sformatf("v%0d xp_data", i), xp_data, v.e_xd);
        sb.push_back('{i, v.e_npc, v.e_cause});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL v%0d scoreboard empty actual=0 expected=1", i);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d next_pc", e.idx), pc, e.npc);
            chk($sformatf("v%0d cause", e.idx), {30'b0, cause}, {30'b0, e.cause});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // st irq ill src tk imm jt jrt | pc sq we xd ack npc cause
        add(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8000_0000, 0, 0, 32'h0, 0, 32'h8000_0004, 0);
        add(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8000_0004, 0, 0, 32'h0, 0, 32'h8000_0008, 0);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0120, 32'h8000_0008, 0, 0, 32'h0, 0,
            32'h0000_0120, 0);
        // After mid-run reset
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0014, 32'h8000_0000, 0, 0, 32'h0, 0,
            32'h0000_0014, 0);
        add(0, 0, 0, 2, 0, 16'h0, 26'h5E, 32'h0, 32'h0000_0014, 0, 0, 32'h0, 0, 32'h0000_0178, 0);
        add(0, 0, 0, 1, 1, 16'hFFF8, 26'h0, 32'h0, 32'h0000_0178, 0, 0, 32'h0, 0, 32'h0000_015C, 0);
        add(0, 0, 0, 1, 0, 16'hFFF8, 26'h0, 32'h0, 32'h0000_015C, 0, 0, 32'h0, 0, 32'h0000_0160, 0);
        add(0, 1, 0, 2, 0, 16'h0, 26'h2A, 32'h0, 32'h0000_0160, 0, 0, 32'h0, 0, 32'h0000_00A8, 0);
        add(0, 0, 0, 1, 1, 16'h0010, 26'h0, 32'h0, 32'h0000_00A8, 1, 1, 32'h0000_00A8, 1,
            32'h8000_0004, 1);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_00A8, 32'h8000_0004, 0, 0, 32'h0, 0,
            32'h0000_00A8, 1);
        add(0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_00A8, 1, 1, 32'h0000_00AC, 0,
            32'h8000_0008, 2);
        add(0, 0, 0, 2, 0, 16'h0, 26'h32, 32'h0, 32'h8000_0008, 0, 0, 32'h0, 0, 32'h8000_00C8, 2);
        add(0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8000_00C8, 0, 0, 32'h0, 0, 32'h8000_00CC, 2);
        add(0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8000_00CC, 0, 0, 32'h0, 0, 32'h8000_00D0, 2);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0150, 32'h8000_00D0, 0, 0, 32'h0, 0,
            32'h0000_0150, 2);
        add(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_0150, 1, 1, 32'h0000_0150, 1,
            32'h8000_0004, 1);
        add(0, 1, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0040, 32'h8000_0004, 0, 0, 32'h0, 0,
            32'h0000_0040, 1);
        add(0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_0040, 1, 1, 32'h0000_0044, 0,
            32'h8000_0008, 2);
        add(0, 0, 0, 2, 0, 16'h0, 26'h4, 32'h0, 32'h8000_0008, 0, 0, 32'h0, 0, 32'h8000_0010, 2);
        add(0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8000_0010, 0, 0, 32'h0, 0, 32'h8000_0014, 2);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0200, 32'h8000_0014, 0, 0, 32'h0, 0,
            32'h0000_0200, 2);
        add(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_0200, 1, 1, 32'h0000_0200, 1,
            32'h8000_0004, 1);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0300, 32'h8000_0004, 0, 0, 32'h0, 0,
            32'h0000_0300, 1);
        add(1, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_0300, 0, 0, 32'h0, 0, 32'h0000_0300, 1);
        add(1, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_0300, 0, 0, 32'h0, 0, 32'h0000_0300, 1);
        add(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_0300, 1, 1, 32'h0000_0300, 1,
            32'h8000_0004, 1);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0400, 32'h8000_0004, 0, 0, 32'h0, 0,
            32'h0000_0400, 1);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h8000_0000, 32'h0000_0400, 0, 0, 32'h0, 0,
            32'h0000_0000, 1);
        add(0, 0, 0, 3, 0, 16'h0, 26'h0, 32'h8000_0123, 32'h0000_0000, 0, 0, 32'h0, 0,
            32'h0000_0120, 1);
        add(0, 0, 0, 1, 1, 16'h0001, 26'h0, 32'h0, 32'h0000_0120, 0, 0, 32'h0, 0, 32'h0000_0128, 1);

        // Power-on reset, with an illegal_op present that must not matter.
        drive_idle();
        illegal_op = 1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", pc, 32'h8000_0000);
        chk("reset cause", {30'b0, cause}, 32'h0);
        chk("reset squash", {31'b0, squash}, 32'h0);
        chk("reset xp_we", {31'b0, xp_we}, 32'h0);
        chk("reset int_ack", {31'b0, int_ack}, 32'h0);
        drive_idle();
        reset = 0;

        for (int i = 0; i < 3; i++) step(i);

        // Asynchronous reset mid-cycle from a user-space pc.
        @(negedge clk);
        drive_idle();
        #1;
        chk("midrst pc before", pc, 32'h0000_0120);
        #1 reset = 1;
        #1;
        chk("midrst pc async", pc, 32'h8000_0000);
        chk("midrst squash", {31'b0, squash}, 32'h0);
        @(posedge clk);
        #1;
        chk("midrst pc held", pc, 32'h8000_0000);
        reset = 0;

        for (int i = 3; i < vecs.size(); i++) step(i);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
